// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready = ~out_valid | out_ready)
//   A, B, Cin, Sub        operands; Sub=0: A+B+Cin, Sub=1: A-B-Cin
//   out_valid / out_ready result handshake
//   Sum, Cout, Ovf        result, carry-out (not-borrow on sub), signed overflow
// Optional build macro: PIPELINED_CLA_SATURATE_EN clamps Sum on signed overflow.

module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STAGES = WIDTH / BLOCK;

  logic adv;
  logic accept;

  // The whole pipe moves as one shift register; it only freezes when the
  // final stage holds a result nobody is taking.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * BLOCK;
    localparam int HI = LO + BLOCK;

    // Operand bits not yet consumed, carry and valid entering this slice
    logic [WIDTH-1:LO] a_in;
    logic [WIDTH-1:LO] bx_in;
    logic              c_in;
    logic              v_in;

    logic [BLOCK-1:0]  g;
    logic [BLOCK-1:0]  p;
    logic [BLOCK-1:0]  s;
    logic [BLOCK:0]    c;
    logic              gg;
    logic              pp;

    logic [HI-1:0]     sum_cat;
    logic [HI-1:0]     sum_d;
    logic [HI-1:0]     sum_r;
    logic              c_r;
    logic              v_r;

    if (k == 0) begin : head
      assign a_in    = A;
      assign bx_in   = Sub ? ~B : B;
      assign c_in    = Sub ? ~Cin : Cin;
      assign v_in    = accept;
      assign sum_cat = s;
    end else begin : body
      assign a_in    = stg[k-1].mid.a_r;
      assign bx_in   = stg[k-1].mid.bx_r;
      assign c_in    = stg[k-1].c_r;
      assign v_in    = stg[k-1].v_r;
      assign sum_cat = {s, stg[k-1].sum_r};
    end

    // Each carry is a group-generate / group-propagate of bits [i:0] applied
    // to the slice carry-in, so no carry depends on a lower carry.
    always_comb begin
      g    = a_in[HI-1:LO] & bx_in[HI-1:LO];
      p    = a_in[HI-1:LO] ^ bx_in[HI-1:LO];
      gg   = 1'b0;
      pp   = 1'b1;
      c    = '0;
      c[0] = c_in;
      for (int i = 0; i < BLOCK; i++) begin
        gg     = g[i] | (p[i] & gg);
        pp     = pp & p[i];
        c[i+1] = gg | (pp & c_in);
      end
      s = p ^ c[BLOCK-1:0];
    end

    if (k == STAGES - 1) begin : fin
      logic ovf_d;
      logic ovf_r;

      assign ovf_d = c[BLOCK] ^ c[BLOCK-1];

`ifdef PIPELINED_CLA_SATURATE_EN
      localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
      // A's sign decides direction: a positive A can only overflow upward.
      assign sum_d = ovf_d ? (a_in[WIDTH-1] ? ~SAT_MAX : SAT_MAX) : sum_cat;
`else
      assign sum_d = sum_cat;
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (adv) begin
          ovf_r <= ovf_d;
        end
      end
    end else begin : mid
      logic [WIDTH-1:HI] a_r;
      logic [WIDTH-1:HI] bx_r;

      assign sum_d = sum_cat;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_r  <= '0;
          bx_r <= '0;
        end else if (adv) begin
          a_r  <= a_in[WIDTH-1:HI];
          bx_r <= bx_in[WIDTH-1:HI];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        sum_r <= '0;
      end else if (adv) begin
        v_r   <= v_in;
        c_r   <= c[BLOCK];
        sum_r <= sum_d;
      end
    end
  end

  assign out_valid = stg[STAGES-1].v_r;
  assign Sum       = stg[STAGES-1].sum_r;
  assign Cout      = stg[STAGES-1].c_r;
  assign Ovf       = stg[STAGES-1].fin.ovf_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - scoreboard bench for pipelined_cla_adder

module tb_pipelined_cla_adder;

  localparam int W      = 32;
  localparam int BLK    = 8;
  localparam int STAGES = W / BLK;

`ifdef PIPELINED_CLA_SATURATE_EN
  localparam logic [W-1:0] D1_SUM = 32'h7FFF_FFFF;
  localparam logic [W-1:0] D4_SUM = 32'h8000_0000;
  localparam logic [W-1:0] D5_SUM = 32'h8000_0000;
`else
  localparam logic [W-1:0] D1_SUM = 32'h8000_0000;
  localparam logic [W-1:0] D4_SUM = 32'h7FFF_FFFF;
  localparam logic [W-1:0] D5_SUM = 32'h0000_0000;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(W), .BLOCK(BLK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur_exp;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  bit           lat_mode = 0;
  bit           bp_mode  = 0;
  int           stall_lo = 0;
  bit           hold_pend = 0;
  bit           acc_dummy;
  logic [W-1:0] held_sum;
  logic         held_cout;
  logic         held_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov);
    exp_t r;
    r.sum  = s;
    r.cout = co;
    r.ovf  = ov;
    r.cyc  = 0;
    r.lat  = 0;
    return r;
  endfunction

  // Behavioural reference: plain wide addition, overflow from operand/result signs
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W-1:0] bx;
    logic [W:0]   full;
    exp_t         r;
    bx    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (sub ? ~cin : cin)};
    r     = mk(full[W-1:0], full[W], 1'b0);
    r.ovf = (a[W-1] == bx[W-1]) && (r.sum[W-1] != a[W-1]);
`ifdef PIPELINED_CLA_SATURATE_EN
    if (r.ovf) r.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return r;
  endfunction

  // One clock: observe at negedge, account for the handshakes that will
  // complete on the coming posedge, then return #1 after that posedge.
  task automatic step(output bit acc);
    exp_t e;
    acc = 0;
    if (bp_mode) out_ready = !(cyc >= stall_lo && cyc < stall_lo + 3);
    @(negedge clk);
    if (rst_n) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (hold_pend) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_sum", {32'd0, Sum}, {32'd0, held_sum});
        check("hold_cout", {63'd0, Cout}, {63'd0, held_cout});
        check("hold_ovf", {63'd0, Ovf}, {63'd0, held_ovf});
        hold_pend = 0;
      end
      if (out_valid && !out_ready) begin
        held_sum  = Sum;
        held_cout = Cout;
        held_ovf  = Ovf;
        hold_pend = 1;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sum", {32'd0, Sum}, {32'd0, e.sum});
          check("cout", {63'd0, Cout}, {63'd0, e.cout});
          check("ovf", {63'd0, Ovf}, {63'd0, e.ovf});
          if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(STAGES));
        end
      end
      if (in_valid && in_ready) begin
        e     = cur_exp;
        e.cyc = cyc;
        e.lat = lat_mode;
        sb.push_back(e);
        acc = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input exp_t e);
    bit acc;
    int n;
    A = a; B = b; Cin = cin; Sub = sub; cur_exp = e; in_valid = 1;
    acc = 0;
    n = 0;
    while (!acc && n < 20) begin
      step(acc);
      n++;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    in_valid = 0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step(acc_dummy);
      n++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_sum"}, {32'd0, Sum}, 64'd0);
    check({tag, "_cout"}, {63'd0, Cout}, 64'd0);
    check({tag, "_ovf"}, {63'd0, Ovf}, 64'd0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;

    // Reset with handshake inputs active: they must be ignored
    rst_n = 0; in_valid = 1; out_ready = 0;
    A = '1; B = '1; Cin = 1; Sub = 0;
    cur_exp = mk('0, 1'b0, 1'b0);
    repeat (3) step(acc_dummy);
    in_valid = 0; rst_n = 1; out_ready = 1;
    check_idle("reset");

    // Directed corners, back-to-back, no stalls: latency is checked too
    lat_mode = 1;
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(D1_SUM, 1'b0, 1'b1));
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(D4_SUM, 1'b1, 1'b1));
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, mk(D5_SUM, 1'b1, 1'b1));
    send(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, mk(32'h0000_000C, 1'b1, 1'b0));
    send(32'h00FF_00FF, 32'h0001_FF01, 1'b0, 1'b0, mk(32'h0101_0000, 1'b0, 1'b0));
    drain();
    lat_mode = 0;

    // Backpressure: 8 beats, downstream stalls 3 cycles mid-stream
    bp_mode  = 1;
    stall_lo = cyc + 6;
    for (int i = 0; i < 8; i++) begin
      ra = 32'h1000_0000 * i + 32'h0F0F_0F0F;
      rb = 32'h0101_0101 * (i + 1);
      send(ra, rb, i[0], i[1], model(ra, rb, i[0], i[1]));
    end
    drain();
    bp_mode   = 0;
    out_ready = 1;

    // Reset with three beats in flight: none may ever emerge
    for (int i = 0; i < 3; i++) begin
      ra = 32'hFFFF_FFF0 + i;
      send(ra, 32'h11, 1'b1, 1'b0, model(ra, 32'h11, 1'b1, 1'b0));
    end
    rst_n = 0; in_valid = 1;
    step(acc_dummy);
    rst_n = 1; in_valid = 0;
    sb.delete();
    check_idle("flush");
    repeat (10) step(acc_dummy);

    // Random traffic with random valid/ready against the reference model
    for (int i = 0; i < 3000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = '1;
        1: rb = 32'h8000_0000;
        2: ra = 32'h7FFF_FFFF;
        default: ;
      endcase
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      A = ra; B = rb; Cin = rc; Sub = rs;
      cur_exp   = model(ra, rb, rc, rs);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc_dummy);
    end
    out_ready = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
